// File: rtl/apb_master_bridge_if.sv
// Purpose: command/response stream plus APB bus signals shared by the bridge and its environment.
// Latency: none, wires only.
// Backpressure: carries cmd_ready/rsp_ready handshakes and the APB PREADY wait signal.
interface apb_master_bridge_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) ();

  // Command stream from the source into the bridge
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;

  // Response stream from the bridge back to the source
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_write;
  logic                  rsp_err;

  // APB bus towards the slave
  logic                  PSEL;
  logic                  PENABLE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic                  PWRITE;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;

  // Bridge status
  logic                  busy;

  // Bridge side: consumes commands, produces responses, owns the APB request signals
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_write, rsp_err,
    input  rsp_ready,
    output PSEL, PENABLE, PADDR, PWRITE, PWDATA,
    input  PRDATA, PREADY,
    output busy
  );

  // Environment side: command source, response sink and APB slave
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_write, rsp_err,
    output rsp_ready,
    input  PSEL, PENABLE, PADDR, PWRITE, PWDATA,
    output PRDATA, PREADY,
    input  busy
  );

endinterface

// File: rtl/apb_master_bridge.sv
// Purpose: turns a valid/ready command stream into APB transfers and returns data plus a timeout status.
// Latency: accept at E, PSEL from E, PENABLE from E+1, response from E+2 (zero-wait), next accept at E+4.
// Backpressure: one transfer in flight; cmd_ready drops until the response is taken; hung PREADY aborts after TIMEOUT_CYCLES.
module apb_master_bridge #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                PCLK,
  input  logic                PRESET,
  apb_master_bridge_if.master bus
);

  // Counter must hold TIMEOUT_CYCLES itself; keep at least one bit when the timeout is disabled
  localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_EN ? TIMEOUT_CYCLES - 1 : 0);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [CNT_W-1:0]      wait_cnt;

  logic                  cmd_ready_q;
  logic                  busy_q;

  logic                  psel_q;
  logic                  penable_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic                  pwrite_q;
  logic [DATA_WIDTH-1:0] pwdata_q;

  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  rsp_write_q;
  logic                  rsp_err_q;

  logic                  accept;
  logic                  xfer_done;
  logic                  xfer_timeout;
  logic                  rsp_taken;

  // cmd_ready_q is only high in IDLE, so this is the IDLE-state handshake
  assign accept       = cmd_ready_q && bus.cmd_valid;
  // PREADY wins over an expiring counter on the same edge
  assign xfer_done    = (state == ACCESS) && bus.PREADY;
  assign xfer_timeout = (state == ACCESS) && !bus.PREADY && TIMEOUT_EN && (wait_cnt == CNT_LAST);
  assign rsp_taken    = (state == RESP) && rsp_valid_q && bus.rsp_ready;

  // Next-state decode for the four-phase transfer sequence
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (xfer_done || xfer_timeout) state_nxt = RESP;
      RESP:    if (rsp_taken) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register plus registered cmd_ready/busy derived from the upcoming state
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state       <= IDLE;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state       <= state_nxt;
      cmd_ready_q <= (state_nxt == IDLE);
      busy_q      <= (state_nxt != IDLE);
    end
  end

  // APB request signals: address/data latched on accept and held until the next accept
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
    end else if (accept) begin
      psel_q    <= 1'b1;
      penable_q <= 1'b0;
      paddr_q   <= bus.cmd_addr;
      pwrite_q  <= bus.cmd_write;
      pwdata_q  <= bus.cmd_wdata;
    end else if (state == SETUP) begin
      penable_q <= 1'b1;
    end else if (xfer_done || xfer_timeout) begin
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
    end
  end

  // Counts ACCESS cycles with PREADY low; restarts every time SETUP is entered
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wait_cnt <= '0;
    end else if (state == SETUP) begin
      wait_cnt <= '0;
    end else if ((state == ACCESS) && !bus.PREADY && TIMEOUT_EN && !xfer_timeout) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // Response capture; fields stay frozen in RESP until the consumer takes them
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_write_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else if (xfer_done) begin
      rsp_valid_q <= 1'b1;
      rsp_rdata_q <= pwrite_q ? '0 : bus.PRDATA;
      rsp_write_q <= pwrite_q;
      rsp_err_q   <= 1'b0;
    end else if (xfer_timeout) begin
      rsp_valid_q <= 1'b1;
      rsp_rdata_q <= '0;
      rsp_write_q <= pwrite_q;
      rsp_err_q   <= 1'b1;
    end else if (rsp_taken) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.busy      = busy_q;
  assign bus.PSEL      = psel_q;
  assign bus.PENABLE   = penable_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_write = rsp_write_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Purpose: directed bench for apb_master_bridge with a simple wait-state APB slave and a scoreboard.
// Latency: drives and samples on the falling clock edge, half a cycle away from the DUT edge.
// Backpressure: exercises rsp_ready stalls, slave wait states and the PREADY timeout.
module tb_apb_master_bridge;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 4;

  logic pclk = 1'b0;
  logic preset = 1'b1;
  int total = 0;
  int bad = 0;

  apb_master_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb_master_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .PCLK   (pclk),
    .PRESET (preset),
    .bus    (bus)
  );

  always #5 pclk = ~pclk;

  // Behavioural APB slave: PREADY after wait_cycles ACCESS cycles, or never when force_low
  logic [DW-1:0] smem [0:255] = '{default: '0};
  logic [DW-1:0] model [0:255] = '{default: '0};
  int wcnt = 0;
  int wait_cycles = 0;
  bit force_low = 1'b0;

  assign bus.PREADY = bus.PSEL && bus.PENABLE && !force_low && (wcnt >= wait_cycles);
  assign bus.PRDATA = smem[bus.PADDR];

  // Slave wait counter and write port
  always @(posedge pclk) begin
    if (bus.PSEL && bus.PENABLE && !bus.PREADY) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (bus.PSEL && bus.PENABLE && bus.PREADY && bus.PWRITE) smem[bus.PADDR] <= bus.PWDATA;
  end

  // Issues one command with rsp_ready=1 and measures PSEL/PENABLE cycles and response latency
  task automatic run_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         output int n_sel, output int n_en, output int lat,
                         output logic [DW-1:0] rd, output logic rw, output logic re, output bit ok);
    int guard;
    n_sel = 0; n_en = 0; lat = -1; rd = '0; rw = 1'b0; re = 1'b0; ok = 1'b0;
    bus.rsp_ready = 1'b1;
    bus.cmd_write = w; bus.cmd_addr = a; bus.cmd_wdata = d; bus.cmd_valid = 1'b1;
    guard = 0;
    while (!bus.cmd_ready && guard < 50) begin @(negedge pclk); guard++; end
    if (!bus.cmd_ready) begin bus.cmd_valid = 1'b0; return; end
    @(negedge pclk);
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (bus.PSEL) n_sel++;
      if (bus.PENABLE) n_en++;
      if (bus.rsp_valid) begin
        lat = i; rd = bus.rsp_rdata; rw = bus.rsp_write; re = bus.rsp_err; ok = 1'b1;
        break;
      end
      @(negedge pclk);
    end
  endtask

  task automatic test_reset();
    preset = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(negedge pclk);
    preset = 1'b0;
    total++; if ({bus.PSEL, bus.PENABLE, bus.PWRITE} !== 3'b000) begin bad++;
      $display("FAIL reset_apb_ctl: got %b required 000", {bus.PSEL, bus.PENABLE, bus.PWRITE}); end
    total++; if (bus.PADDR !== 8'h00) begin bad++; $display("FAIL reset_paddr: got %h required 00", bus.PADDR); end
    total++; if (bus.PWDATA !== 32'h0) begin bad++; $display("FAIL reset_pwdata: got %h required 0", bus.PWDATA); end
    total++; if ({bus.rsp_valid, bus.rsp_write, bus.rsp_err} !== 3'b000) begin bad++;
      $display("FAIL reset_rsp_ctl: got %b required 000", {bus.rsp_valid, bus.rsp_write, bus.rsp_err}); end
    total++; if (bus.rsp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h required 0", bus.rsp_rdata); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b required 0", bus.busy); end
    total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready: got %b required 1", bus.cmd_ready); end
  endtask

  task automatic test_write_zero_wait();
    int n_sel, n_en, lat; logic [DW-1:0] rd; logic rw, re; bit ok;
    wait_cycles = 0; force_low = 1'b0;
    run_cmd(1'b1, 8'h04, 32'hDEADBEEF, n_sel, n_en, lat, rd, rw, re, ok);
    total++; if (ok != 1'b1) begin bad++; $display("FAIL wr_rsp_seen: got %0b required 1", ok); end
    total++; if (n_sel !== 2) begin bad++; $display("FAIL wr_psel_cycles: got %0d required 2", n_sel); end
    total++; if (n_en !== 1) begin bad++; $display("FAIL wr_penable_cycles: got %0d required 1", n_en); end
    total++; if (lat !== 2) begin bad++; $display("FAIL wr_latency: got %0d required 2", lat); end
    total++; if ({rw, re} !== 2'b10) begin bad++; $display("FAIL wr_rsp_flags: write/err got %b required 10", {rw, re}); end
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL wr_rdata: got %h required 0", rd); end
    total++; if (smem[4] !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_slave_mem: got %h required deadbeef", smem[4]); end
  endtask

  task automatic test_read_wait3();
    int n_sel, n_en, lat; logic [DW-1:0] rd; logic rw, re; bit ok;
    @(negedge pclk);
    wait_cycles = 3; force_low = 1'b0;
    run_cmd(1'b0, 8'h04, 32'h5A5A5A5A, n_sel, n_en, lat, rd, rw, re, ok);
    total++; if (ok != 1'b1) begin bad++; $display("FAIL rd3_rsp_seen: got %0b required 1", ok); end
    total++; if (n_en !== 4) begin bad++; $display("FAIL rd3_penable_cycles: got %0d required 4", n_en); end
    total++; if (lat !== 5) begin bad++; $display("FAIL rd3_latency: got %0d required 5", lat); end
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL rd3_rdata: got %h required deadbeef", rd); end
    total++; if ({rw, re} !== 2'b00) begin bad++; $display("FAIL rd3_rsp_flags: write/err got %b required 00", {rw, re}); end
  endtask

  task automatic test_timeout();
    int n_sel, n_en, lat; logic [DW-1:0] rd; logic rw, re; bit ok;
    // PREADY stuck low: abort after exactly TO ACCESS cycles
    @(negedge pclk);
    wait_cycles = 0; force_low = 1'b1;
    run_cmd(1'b0, 8'h04, 32'h0, n_sel, n_en, lat, rd, rw, re, ok);
    force_low = 1'b0;
    total++; if (ok != 1'b1) begin bad++; $display("FAIL to_rsp_seen: got %0b required 1", ok); end
    total++; if (n_en !== 4) begin bad++; $display("FAIL to_penable_cycles: got %0d required 4", n_en); end
    total++; if (n_sel !== 5) begin bad++; $display("FAIL to_psel_cycles: got %0d required 5", n_sel); end
    total++; if (bus.PSEL !== 1'b0) begin bad++; $display("FAIL to_psel_dropped: got %b required 0", bus.PSEL); end
    total++; if (re !== 1'b1) begin bad++; $display("FAIL to_err: got %b required 1", re); end
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL to_rdata: got %h required 0", rd); end
    // PREADY on the 4th ACCESS cycle, same edge the counter expires: success
    @(negedge pclk);
    wait_cycles = 3;
    run_cmd(1'b0, 8'h04, 32'h0, n_sel, n_en, lat, rd, rw, re, ok);
    total++; if (ok != 1'b1) begin bad++; $display("FAIL to_edge_rsp_seen: got %0b required 1", ok); end
    total++; if (re !== 1'b0) begin bad++; $display("FAIL to_edge_err: got %b required 0", re); end
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL to_edge_rdata: got %h required deadbeef", rd); end
    // PREADY would come on the 5th ACCESS cycle: too late
    @(negedge pclk);
    wait_cycles = 4;
    run_cmd(1'b0, 8'h04, 32'h0, n_sel, n_en, lat, rd, rw, re, ok);
    total++; if ({ok, re, n_en} !== {1'b1, 1'b1, 32'd4}) begin bad++;
      $display("FAIL to_late_ready: seen/err/penable got %0b/%0b/%0d required 1/1/4", ok, re, n_en); end
  endtask

  task automatic test_backpressure();
    int guard;
    @(negedge pclk);
    wait_cycles = 0; force_low = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.cmd_write = 1'b1; bus.cmd_addr = 8'h08; bus.cmd_wdata = 32'h12345678; bus.cmd_valid = 1'b1;
    guard = 0;
    while (!bus.cmd_ready && guard < 50) begin @(negedge pclk); guard++; end
    @(negedge pclk);
    bus.cmd_write = 1'b0; bus.cmd_addr = 8'h08; bus.cmd_wdata = 32'h0;
    guard = 0;
    while (!bus.rsp_valid && guard < 20) begin @(negedge pclk); guard++; end
    total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_first_rsp: got %b required 1", bus.rsp_valid); end
    for (int i = 0; i < 10; i++) begin
      total++;
      if ({bus.rsp_valid, bus.rsp_write, bus.rsp_err, bus.cmd_ready, bus.PSEL} !== 5'b11000 || bus.rsp_rdata !== 32'h0) begin
        bad++;
        $display("FAIL bp_hold cycle %0d: valid/write/err/cmd_ready/psel got %b rdata %h required 11000 rdata 0",
                 i, {bus.rsp_valid, bus.rsp_write, bus.rsp_err, bus.cmd_ready, bus.PSEL}, bus.rsp_rdata);
      end
      @(negedge pclk);
    end
    bus.rsp_ready = 1'b1;
    @(negedge pclk);
    total++; if ({bus.cmd_ready, bus.rsp_valid, bus.PSEL} !== 3'b100) begin bad++;
      $display("FAIL bp_release: cmd_ready/rsp_valid/psel got %b required 100", {bus.cmd_ready, bus.rsp_valid, bus.PSEL}); end
    @(negedge pclk);
    bus.cmd_valid = 1'b0;
    total++; if ({bus.PSEL, bus.PENABLE, bus.PWRITE} !== 3'b100 || bus.PADDR !== 8'h08) begin bad++;
      $display("FAIL bp_second_accept: psel/penable/pwrite got %b paddr %h required 100 paddr 08",
               {bus.PSEL, bus.PENABLE, bus.PWRITE}, bus.PADDR); end
    guard = 0;
    while (!bus.rsp_valid && guard < 20) begin @(negedge pclk); guard++; end
    total++; if ({bus.rsp_valid, bus.rsp_write, bus.rsp_err} !== 3'b100 || bus.rsp_rdata !== 32'h12345678) begin bad++;
      $display("FAIL bp_second_rsp: valid/write/err got %b rdata %h required 100 rdata 12345678",
               {bus.rsp_valid, bus.rsp_write, bus.rsp_err}, bus.rsp_rdata); end
  endtask

  task automatic test_reset_mid_access();
    int guard;
    @(negedge pclk);
    force_low = 1'b1; wait_cycles = 0;
    bus.rsp_ready = 1'b1;
    bus.cmd_write = 1'b1; bus.cmd_addr = 8'h10; bus.cmd_wdata = 32'hA5A5A5A5; bus.cmd_valid = 1'b1;
    guard = 0;
    while (!bus.cmd_ready && guard < 50) begin @(negedge pclk); guard++; end
    @(negedge pclk);
    bus.cmd_valid = 1'b0;
    @(negedge pclk);
    total++; if (bus.PENABLE !== 1'b1) begin bad++; $display("FAIL rst_mid_in_access: penable got %b required 1", bus.PENABLE); end
    preset = 1'b1;
    @(negedge pclk);
    preset = 1'b0;
    force_low = 1'b0;
    total++; if ({bus.PSEL, bus.PENABLE, bus.rsp_valid, bus.busy, bus.cmd_ready} !== 5'b00001) begin bad++;
      $display("FAIL rst_mid_ctl: psel/penable/rsp_valid/busy/cmd_ready got %b required 00001",
               {bus.PSEL, bus.PENABLE, bus.rsp_valid, bus.busy, bus.cmd_ready}); end
    total++; if (bus.PADDR !== 8'h00 || bus.PWDATA !== 32'h0) begin bad++;
      $display("FAIL rst_mid_bus: paddr %h pwdata %h required 00 and 0", bus.PADDR, bus.PWDATA); end
    for (int i = 0; i < 6; i++) begin
      @(negedge pclk);
      total++; if (bus.rsp_valid !== 1'b0 || bus.PSEL !== 1'b0) begin bad++;
        $display("FAIL rst_mid_no_rsp cycle %0d: rsp_valid %b psel %b required 0 0", i, bus.rsp_valid, bus.PSEL); end
    end
    total++; if (smem[8'h10] !== 32'h0) begin bad++; $display("FAIL rst_mid_no_write: mem got %h required 0", smem[8'h10]); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_d [$];
    logic exp_w [$];
    logic [DW-1:0] ed;
    logic ew;
    int issued = 0;
    int got = 0;
    bit pend = 1'b0;
    logic prev_sel = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    @(negedge pclk);
    wait_cycles = 0; force_low = 1'b0; bus.rsp_ready = 1'b1;
    bus.cmd_write = 1'($urandom_range(0, 1));
    bus.cmd_addr = AW'(32'h20 + $urandom_range(0, 15));
    bus.cmd_wdata = $urandom;
    bus.cmd_valid = 1'b1;
    for (int cyc = 0; cyc < 800 && got < 50; cyc++) begin
      total++; if (bus.PENABLE && !bus.PSEL) begin bad++;
        $display("FAIL b2b_penable_without_psel cycle %0d: penable %b psel %b", cyc, bus.PENABLE, bus.PSEL); end
      total++; if (prev_sel && bus.PSEL && bus.PADDR !== prev_addr) begin bad++;
        $display("FAIL b2b_paddr_stable cycle %0d: got %h required %h", cyc, bus.PADDR, prev_addr); end
      prev_sel = bus.PSEL; prev_addr = bus.PADDR;
      if (bus.rsp_valid) begin
        total++;
        if (exp_d.size() == 0) begin
          bad++; $display("FAIL b2b_unexpected_rsp cycle %0d: rdata %h", cyc, bus.rsp_rdata);
        end else begin
          ed = exp_d.pop_front(); ew = exp_w.pop_front();
          if (bus.rsp_rdata !== ed || bus.rsp_write !== ew || bus.rsp_err !== 1'b0) begin
            bad++;
            $display("FAIL b2b_rsp #%0d: rdata %h write %b err %b required rdata %h write %b err 0",
                     got, bus.rsp_rdata, bus.rsp_write, bus.rsp_err, ed, ew);
          end
        end
        got++;
      end
      if (pend) begin
        if (bus.cmd_write) begin
          model[bus.cmd_addr] = bus.cmd_wdata;
          exp_d.push_back('0); exp_w.push_back(1'b1);
        end else begin
          exp_d.push_back(model[bus.cmd_addr]); exp_w.push_back(1'b0);
        end
        issued++;
        if (issued < 50) begin
          bus.cmd_write = 1'($urandom_range(0, 1));
          bus.cmd_addr = AW'(32'h20 + $urandom_range(0, 15));
          bus.cmd_wdata = $urandom;
        end else begin
          bus.cmd_valid = 1'b0;
        end
      end
      pend = bus.cmd_valid && bus.cmd_ready;
      @(negedge pclk);
    end
    bus.cmd_valid = 1'b0;
    total++; if (got !== 50) begin bad++; $display("FAIL b2b_rsp_count: got %0d required 50", got); end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    @(negedge pclk);
    test_reset();
    test_write_zero_wait();
    test_read_wait3();
    test_timeout();
    test_backpressure();
    test_reset_mid_access();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Upstream stage of apb_slave_ip: converts a simple valid/ready command stream into APB transfers on the shared apb_intf signals. It returns read data and a status response.
- Sits between the testbench/bus-fabric command source and the slave. It owns PSEL, PENABLE, PADDR, PWRITE and PWDATA.
- Adds a PREADY timeout so a hung slave cannot stall the command source forever.

Parameters:
- ADDR_WIDTH, 8: width of PADDR and cmd_addr.
- DATA_WIDTH, 32: width of PWDATA, PRDATA, cmd_wdata and rsp_rdata.
- TIMEOUT_CYCLES, 16: maximum number of ACCESS cycles with PREADY low before the transfer is aborted. 0 disables the timeout.

Ports:
- PCLK  in  1  APB clock; all logic on rising edge.
- PRESET  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  bridge accepts command this cycle.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_WIDTH  target address.
- cmd_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer takes response.
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes and for errors).
- rsp_write  out  1  echo of cmd_write for this response.
- rsp_err  out  1  1 = transfer timed out.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PADDR  out  ADDR_WIDTH  APB address.
- PWRITE  out  1  APB direction.
- PWDATA  out  DATA_WIDTH  APB write data.
- PRDATA  in  DATA_WIDTH  APB read data.
- PREADY  in  1  APB ready from the slave.
- busy  out  1  high in every state except IDLE.

Behaviour:
Outputs and reset:
- All outputs are registered.
- PRESET high at a rising edge forces the following values at the next edge, regardless of state:
  - state=IDLE.
  - PSEL=0, PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0.
  - rsp_valid=0, rsp_rdata=0, rsp_write=0, rsp_err=0.
  - wait counter=0, busy=0.
- Reset mid-transfer abandons the transfer silently; no response is produced.

FSM states are IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready=1.
  - cmd_valid&cmd_ready at edge E latches addr, write and wdata, drives PADDR/PWRITE/PWDATA, and sets PSEL=1, PENABLE=0. State goes to SETUP.
- SETUP:
  - Lasts exactly one cycle.
  - Next edge sets PENABLE=1 and clears the wait counter. State goes to ACCESS.
- ACCESS:
  - PREADY=1 at an edge completes the transfer:
    - PSEL=0, PENABLE=0.
    - For reads, rsp_rdata=PRDATA; for writes, rsp_rdata=0.
    - rsp_write=latched write, rsp_err=0, rsp_valid=1. State goes to RESP.
  - PREADY=0 increments the wait counter.
  - If TIMEOUT_CYCLES≠0 and the counter already equals TIMEOUT_CYCLES-1 at that edge, the transfer aborts:
    - PSEL=0, PENABLE=0.
    - rsp_err=1, rsp_rdata=0, rsp_valid=1. State goes to RESP.
- RESP:
  - rsp_valid and all rsp_* are held stable until rsp_valid&rsp_ready.
  - At that edge rsp_valid=0 and the state returns to IDLE.
- cmd_ready is 0 in SETUP, ACCESS and RESP. A cmd_valid held high waits and is accepted in IDLE.

Signal holding and latency:
- PADDR, PWRITE and PWDATA stay constant from SETUP through the end of ACCESS, and keep their values while idle until the next accept.
- For reads, PWDATA carries the latched cmd_wdata (don't-care, but deterministic).
- Latency with a zero-wait slave and rsp_ready=1:
  - accept at edge E;
  - PSEL=1 from E;
  - PENABLE=1 from E+1;
  - PREADY is sampled at E+2, so rsp_valid=1 from E+2 to E+3;
  - next cmd_ready at E+3.
  - Minimum spacing is therefore 4 cycles per transfer.
- Each wait state adds one cycle.
- Timeout:
  - The counter width holds TIMEOUT_CYCLES without overflow.
  - A slave with WAIT_CYCLES_COUNT < TIMEOUT_CYCLES never times out.
  - A PREADY arriving on the same edge the counter would expire is a success: PREADY has priority.

Test Plan:
- Write, zero-wait slave: cmd write addr=0x04 data=0xDEADBEEF -> PSEL 1 for 2 cycles, PENABLE high 1 cycle with PADDR=0x04 and PWDATA=0xDEADBEEF; rsp_valid 3 cycles after accept with rsp_err=0, rsp_write=1, rsp_rdata=0.
- Read back, slave WAIT_CYCLES_COUNT=3: read addr=0x04 -> PENABLE high 4 cycles; rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid 6 cycles after accept.
- Timeout, TIMEOUT_CYCLES=4, PREADY forced 0 -> PENABLE high exactly 4 cycles, then PSEL=0; rsp_err=1, rsp_rdata=0. Repeat with PREADY=1 on the 4th ACCESS cycle -> rsp_err=0.
- Backpressure: rsp_ready=0 for 10 cycles with cmd_valid held for a second command -> rsp_* stable and cmd_ready=0 throughout; second command accepted the cycle after rsp_ready rises, with PSEL=1 on the following cycle.
- Reset mid-ACCESS (PREADY low, PRESET=1 for 1 cycle) -> next edge PSEL=PENABLE=rsp_valid=busy=0 and PADDR=0; no response for the aborted command.
- Back-to-back stress: 50 random reads/writes with rsp_ready=1 against a zero-wait slave -> readback matches a scoreboard model; never PENABLE=1 while PSEL=0; no PADDR change while PSEL=1.
